// File: rtl/fetch_decode.sv
// Multi-cycle fetch/decode/execute/writeback core: 9-bit ISA, four registers, external combinational ALU.
// Optional macro FETCH_DECODE_DBG_EN adds a register read-back port (dbg_sel/dbg_data) for a display.
module fetch_decode #(
  parameter int PC_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  output logic [PC_WIDTH-1:0] imem_addr,
  output logic                imem_req,
  input  logic                imem_ack,
  input  logic [8:0]          imem_data,
  output logic [8:0]          alu_a,
  output logic [8:0]          alu_b,
  output logic [3:0]          alu_op,
  input  logic [8:0]          alu_result,
  output logic                retired,
  output logic                halted
`ifdef FETCH_DECODE_DBG_EN
  ,
  input  logic [1:0]          dbg_sel,
  output logic [8:0]          dbg_data
`endif
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    WRITEBACK = 3'd3,
    HALTED    = 3'd4
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'b1011;
  localparam logic [3:0] OP_HALT = 4'b1111;

  state_t                state_r;
  state_t                state_s;
  logic [PC_WIDTH-1:0]   pc_r;
  logic [8:0]            ir_r;
  logic [8:0]            regs_r [0:3];
  logic [8:0]            result_r;
  logic [8:0]            alu_a_r;
  logic [8:0]            alu_b_r;
  logic [3:0]            alu_op_r;

  logic [3:0]            opcode_s;
  logic [1:0]            rd_s;
  logic [1:0]            rs_s;
  logic [8:0]            imm_s;
  logic [8:0]            opa_s;
  logic [8:0]            opb_s;
  logic [3:0]            op_s;
  logic                  wr_en_s;

  assign opcode_s = ir_r[8:5];
  assign rd_s     = ir_r[4:3];
  assign rs_s     = ir_r[2:1];
  assign imm_s    = {6'd0, ir_r[2:0]};
  assign wr_en_s  = (opcode_s < 4'd11);

  assign imem_addr = pc_r;
  assign alu_a     = alu_a_r;
  assign alu_b     = alu_b_r;
  assign alu_op    = alu_op_r;

  // Status strobes follow the state register but are forced low while reset is asserted.
  assign imem_req = (state_r == FETCH)     && !reset;
  assign retired  = (state_r == WRITEBACK) && !reset;
  assign halted   = (state_r == HALTED)    && !reset;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= FETCH;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      FETCH: begin
        if (imem_ack) begin
          state_s = DECODE;
        end else begin
          state_s = FETCH;
        end
      end
      DECODE: begin
        if (opcode_s == OP_HALT) begin
          state_s = HALTED;
        end else begin
          state_s = EXECUTE;
        end
      end
      EXECUTE:   state_s = WRITEBACK;
      WRITEBACK: state_s = FETCH;
      HALTED:    state_s = HALTED;
      default:   state_s = FETCH;
    endcase
  end

  // Operand and opcode selection for the ALU.
  always_comb begin
    opa_s = 9'd0;
    opb_s = 9'd0;
    op_s  = opcode_s;
    case (opcode_s)
      4'd0, 4'd1, 4'd3, 4'd7: begin
        opa_s = regs_r[rd_s];
        opb_s = regs_r[rs_s];
      end
      4'd2, 4'd4, 4'd5, 4'd6: begin
        opa_s = regs_r[rs_s];
        opb_s = 9'd0;
      end
      4'd8, 4'd9: begin
        opa_s = regs_r[rd_s];
        opb_s = imm_s;
      end
      4'd10: begin
        opa_s = 9'd0;
        opb_s = imm_s;
      end
      default: begin
        // NOP, undefined and HALT all present as a no-op to the ALU.
        opa_s = 9'd0;
        opb_s = 9'd0;
        op_s  = OP_NOP;
      end
    endcase
  end

  // Datapath: instruction latch, ALU operand registers, result capture, register file and PC.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r     <= '0;
      ir_r     <= 9'd0;
      result_r <= 9'd0;
      alu_a_r  <= 9'd0;
      alu_b_r  <= 9'd0;
      alu_op_r <= OP_NOP;
      for (int i = 0; i < 4; i++) begin
        regs_r[i] <= 9'd0;
      end
    end else begin
      case (state_r)
        FETCH: begin
          if (imem_ack) begin
            ir_r <= imem_data;
          end
        end
        DECODE: begin
          if (opcode_s != OP_HALT) begin
            alu_a_r  <= opa_s;
            alu_b_r  <= opb_s;
            alu_op_r <= op_s;
          end
        end
        EXECUTE: begin
          result_r <= alu_result;
        end
        WRITEBACK: begin
          if (wr_en_s) begin
            regs_r[rd_s] <= result_r;
          end
          pc_r <= pc_r + PC_WIDTH'(1);
        end
        default: begin
        end
      endcase
    end
  end

`ifdef FETCH_DECODE_DBG_EN
  assign dbg_data = regs_r[dbg_sel];
`endif

endmodule
